// File: rtl/video_ts_pkg.sv
// Shared constants and types for the tile/sprite renderer.
package video_ts_pkg;

   // Line-buffer geometry: positions at or above LB_VISIBLE are never written.
   localparam int                LB_AW      = 9;
   localparam logic [LB_AW-1:0]  LB_VISIBLE = LB_AW'(360);

   // Renderer control states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAW  = 2'd2
   } state_e;

   // Nibble index (nibble k = word[4k+3:4k]) for each pixel slot, pc0 in bits [1:0].
   // Unflipped order: [7:4], [3:0], [15:12], [11:8].
   localparam logic [7:0] NIB_SEQ_FWD  = {2'd2, 2'd3, 2'd0, 2'd1};
   // Flipped order: [11:8], [15:12], [3:0], [7:4].
   localparam logic [7:0] NIB_SEQ_FLIP = {2'd1, 2'd0, 2'd3, 2'd2};

endpackage

// File: rtl/video_ts_pixsel.sv
// Combinational 16-to-4 nibble selector: picks the pixel for slot pc of a
// graphics word, honouring X flip.
module video_ts_pixsel
   import video_ts_pkg::*;
(
   input  logic [15:0] word,
   input  logic [1:0]  pc,
   input  logic        xf,
   output logic [3:0]  nibble
);

   logic [7:0] seq;
   logic [1:0] idx;

   // Map the slot to a nibble index, then slice that nibble out of the word.
   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      seq    = xf ? NIB_SEQ_FLIP : NIB_SEQ_FWD;
      idx    = seq[{pc, 1'b0} +: 2];
      nibble = word[{idx, 2'b00} +: 4];
   end

endmodule

// File: rtl/video_ts_render.sv
// Tile/sprite renderer: fetches one horizontal strip of 4bpp graphics from
// DRAM, word by word, and writes its opaque pixels into the scanline buffer.
module video_ts_render
   import video_ts_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              tsr_go,
   input  logic [5:0]        tsr_addr,
   input  logic [8:0]        tsr_line,
   input  logic [7:0]        tsr_page,
   input  logic [8:0]        tsr_x,
   input  logic [2:0]        tsr_xs,
   input  logic              tsr_xf,
   input  logic [3:0]        tsr_pal,
   output logic              tsr_rdy,
   output logic [20:0]       dram_addr,
   output logic              dram_req,
   input  logic              dram_next,
   input  logic [15:0]       dram_rdata,
   output logic [LB_AW-1:0]  lb_addr,
   output logic [7:0]        lb_data,
   output logic              lb_we
);

   state_e            state_q, state_d;
   logic [7:0]        page_q, page_d;
   logic [8:0]        line_q, line_d;
   logic              xf_q, xf_d;
   logic [3:0]        pal_q, pal_d;
   logic [6:0]        col_q, col_d;
   logic [3:0]        wc_q, wc_d;
   logic [LB_AW-1:0]  x_q, x_d;
   logic [1:0]        pc_q, pc_d;
   logic [15:0]       wreg_q, wreg_d;
   logic              rdy_q, rdy_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [LB_AW-1:0]  lb_addr_q, lb_addr_d;
   logic [7:0]        lb_data_q, lb_data_d;

   logic [3:0]        nib;
   logic [3:0]        wc_init;
   logic [6:0]        col_base;
   logic [2:0]        page_lo;

   video_ts_pixsel u_pixsel (
      .word   (wreg_q),
      .pc     (pc_q),
      .xf     (xf_q),
      .nibble (nib)
   );

   // Words per task minus one: 2*(xs+1)-1 is simply {xs,1}.
   assign wc_init  = {tsr_xs, 1'b1};
   assign col_base = {tsr_addr, 1'b0};

   // Page low bits absorb the line's upper bits; the sum wraps within 3 bits.
   assign page_lo   = page_q[2:0] + line_q[8:6];
   assign dram_addr = {page_q[7:3], page_lo, line_q[5:0], col_q};

   assign tsr_rdy  = rdy_q;
   assign dram_req = req_q;
   assign lb_we    = we_q;
   assign lb_addr  = lb_addr_q;
   assign lb_data  = lb_data_q;

   // Next-state and datapath updates; start overrides everything else.
   always_comb begin
      state_d   = state_q;
      page_d    = page_q;
      line_d    = line_q;
      xf_d      = xf_q;
      pal_d     = pal_q;
      col_d     = col_q;
      wc_d      = wc_q;
      x_d       = x_q;
      pc_d      = pc_q;
      wreg_d    = wreg_q;
      rdy_d     = rdy_q;
      req_d     = req_q;
      we_d      = 1'b0;
      lb_addr_d = lb_addr_q;
      lb_data_d = lb_data_q;

      if (start) begin
         state_d = ST_IDLE;
         rdy_d   = 1'b1;
         req_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tsr_go) begin
                  page_d  = tsr_page;
                  line_d  = tsr_line;
                  xf_d    = tsr_xf;
                  pal_d   = tsr_pal;
                  x_d     = tsr_x;
                  wc_d    = wc_init;
                  // Flipped strips start at their last word and walk backwards.
                  col_d   = tsr_xf ? col_base + {3'b000, wc_init} : col_base;
                  rdy_d   = 1'b0;
                  req_d   = 1'b1;
                  state_d = ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (dram_next) begin
                  wreg_d  = dram_rdata;
                  col_d   = xf_q ? col_q - 7'd1 : col_q + 7'd1;
                  pc_d    = 2'd0;
                  req_d   = 1'b0;
                  state_d = ST_DRAW;
               end
            end
            ST_DRAW: begin
               we_d      = (nib != 4'd0) && (x_q < LB_VISIBLE);
               lb_addr_d = x_q;
               lb_data_d = {pal_q, nib};
               x_d       = x_q + 1'b1;
               pc_d      = pc_q + 2'd1;
               if (pc_q == 2'd3) begin
                  if (wc_q == 4'd0) begin
                     rdy_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     wc_d    = wc_q - 4'd1;
                     req_d   = 1'b1;
                     state_d = ST_FETCH;
                  end
               end
            end
            default: begin
               rdy_d   = 1'b1;
               req_d   = 1'b0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         page_q    <= '0;
         line_q    <= '0;
         xf_q      <= 1'b0;
         pal_q     <= '0;
         col_q     <= '0;
         wc_q      <= '0;
         x_q       <= '0;
         pc_q      <= '0;
         wreg_q    <= '0;
         rdy_q     <= 1'b1;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         lb_addr_q <= '0;
         lb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         page_q    <= page_d;
         line_q    <= line_d;
         xf_q      <= xf_d;
         pal_q     <= pal_d;
         col_q     <= col_d;
         wc_q      <= wc_d;
         x_q       <= x_d;
         pc_q      <= pc_d;
         wreg_q    <= wreg_d;
         rdy_q     <= rdy_d;
         req_q     <= req_d;
         we_q      <= we_d;
         lb_addr_q <= lb_addr_d;
         lb_data_q <= lb_data_d;
      end
   end

endmodule

// File: tb/tb_video_ts_render.sv
// Directed bench for video_ts_render with a DRAM responder and a scoreboard
// of expected fetch addresses and line-buffer writes.
module tb_video_ts_render;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        tsr_go;
   logic [5:0]  tsr_addr;
   logic [8:0]  tsr_line;
   logic [7:0]  tsr_page;
   logic [8:0]  tsr_x;
   logic [2:0]  tsr_xs;
   logic        tsr_xf;
   logic [3:0]  tsr_pal;
   logic        tsr_rdy;
   logic [20:0] dram_addr;
   logic        dram_req;
   logic        dram_next;
   logic [15:0] dram_rdata;
   logic [8:0]  lb_addr;
   logic [7:0]  lb_data;
   logic        lb_we;

   typedef struct packed {
      logic [8:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t         exp_wr_q[$];
   logic [20:0] exp_addr_q[$];
   logic [15:0] word_q[$];

   int checks = 0;
   int errors = 0;

   video_ts_render dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .tsr_go     (tsr_go),
      .tsr_addr   (tsr_addr),
      .tsr_line   (tsr_line),
      .tsr_page   (tsr_page),
      .tsr_x      (tsr_x),
      .tsr_xs     (tsr_xs),
      .tsr_xf     (tsr_xf),
      .tsr_pal    (tsr_pal),
      .tsr_rdy    (tsr_rdy),
      .dram_addr  (dram_addr),
      .dram_req   (dram_req),
      .dram_next  (dram_next),
      .dram_rdata (dram_rdata),
      .lb_addr    (lb_addr),
      .lb_data    (lb_data),
      .lb_we      (lb_we)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Word address from page, bitmap line and column, built arithmetically.
   function automatic logic [20:0] model_addr(input int page, input int line, input int col);
      int mid;
      mid = (page + (line / 64)) % 8;
      return 21'((page / 8) * 65536 + mid * 8192 + (line % 64) * 128 + (col % 128));
   endfunction

   // Pixel for slot pc of a word.
   function automatic logic [3:0] model_nib(input logic [15:0] w, input int pc, input logic xf);
      logic [3:0] n;
      if (!xf) begin
         case (pc)
            0: n = w[7:4];
            1: n = w[3:0];
            2: n = w[15:12];
            default: n = w[11:8];
         endcase
      end else begin
         case (pc)
            0: n = w[11:8];
            1: n = w[15:12];
            2: n = w[3:0];
            default: n = w[7:4];
         endcase
      end
      return n;
   endfunction

   // Issue one task, serve DRAM from word_q, and score fetches and writes.
   task automatic run_task(input logic [7:0] page, input logic [8:0] line, input logic [5:0] addr,
                           input logic [2:0] xs, input logic xf, input logic [8:0] x,
                           input logic [3:0] pal, input int stall, input logic spurious);
      int   words, col, xm, cyc, stall_left;
      bit   done;
      wr_t  w;
      words = 2 * (xs + 1);
      col   = xf ? (2 * addr + words - 1) : 2 * addr;
      xm    = x;
      for (int i = 0; i < words; i++) begin
         exp_addr_q.push_back(model_addr(page, line, col));
         col = xf ? (col + 127) % 128 : (col + 1) % 128;
         for (int p = 0; p < 4; p++) begin
            w.addr = 9'(xm);
            w.data = {pal, model_nib(word_q[i], p, xf)};
            if (w.data[3:0] != 4'd0 && xm < 360) exp_wr_q.push_back(w);
            xm = (xm + 1) % 512;
         end
      end
      tsr_page = page; tsr_line = line; tsr_addr = addr; tsr_xs = xs;
      tsr_xf = xf; tsr_x = x; tsr_pal = pal; tsr_go = 1'b1;
      cyc = 0;
      stall_left = stall;
      done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk);
         cyc++;
         if (lb_we) begin
            if (exp_wr_q.size() == 0) check("wr_extra_we", lb_we, 1'b0);
            else begin
               w = exp_wr_q.pop_front();
               check("wr_addr", lb_addr, w.addr);
               check("wr_data", lb_data, w.data);
            end
         end
         if (tsr_rdy) begin
            check("latency", cyc, words * 5 + 1 + stall);
            done = 1'b1;
         end else begin
            tsr_go   = spurious;
            tsr_addr = ~addr;
            if (dram_req) begin
               if (stall_left > 0) begin
                  stall_left--;
                  dram_next  = 1'b0;
                  dram_rdata = 16'hFFFF;
               end else if (exp_addr_q.size() == 0) begin
                  check("extra_req", dram_req, 1'b0);
                  dram_next = 1'b0;
               end else begin
                  check("dram_addr", dram_addr, exp_addr_q.pop_front());
                  dram_next  = 1'b1;
                  dram_rdata = word_q.pop_front();
               end
            end else begin
               dram_next  = spurious;
               dram_rdata = 16'hFFFF;
            end
         end
      end
      if (!done) check("rdy_timeout", tsr_rdy, 1'b1);
      tsr_go    = 1'b0;
      dram_next = 1'b0;
      check("wr_left", exp_wr_q.size(), 0);
      check("addr_left", exp_addr_q.size(), 0);
      exp_wr_q.delete();
      exp_addr_q.delete();
      word_q.delete();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; tsr_go = 1'b0; tsr_addr = '0; tsr_line = '0;
      tsr_page = '0; tsr_x = '0; tsr_xs = '0; tsr_xf = 1'b0; tsr_pal = '0;
      dram_next = 1'b0; dram_rdata = '0;

      // Reset values.
      #12;
      check("rst_rdy", tsr_rdy, 1'b1);
      check("rst_req", dram_req, 1'b0);
      check("rst_we", lb_we, 1'b0);
      check("rst_lb_addr", lb_addr, 9'd0);
      check("rst_lb_data", lb_data, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic unflipped task.
      word_q = '{16'h2143, 16'h8765};
      run_task(8'h10, 9'h045, 6'd3, 3'd0, 1'b0, 9'd100, 4'd5, 0, 1'b0);

      // Same task, X flipped.
      word_q = '{16'h8765, 16'h2143};
      run_task(8'h10, 9'h045, 6'd3, 3'd0, 1'b1, 9'd100, 4'd5, 0, 1'b0);

      // Transparency and right-edge clipping: nothing is written.
      word_q = '{16'h0F00, 16'h0F00};
      run_task(8'h02, 9'h010, 6'd0, 3'd0, 1'b0, 9'd358, 4'd3, 0, 1'b0);

      // Page carry wraps within 3 bits; 4-word flipped strip.
      word_q = '{16'h1234, 16'hABCD, 16'h0000, 16'hF00F};
      run_task(8'h17, 9'h1C0, 6'd5, 3'd1, 1'b1, 9'd20, 4'hA, 0, 1'b0);

      // DRAM stall, column and x wrap, ignored go/dram_next while busy.
      word_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF1};
      run_task(8'h33, 9'h0FF, 6'd63, 3'd1, 1'b0, 9'd510, 4'hC, 20, 1'b1);

      // start beats a simultaneous go in IDLE.
      start = 1'b1; tsr_go = 1'b1;
      @(negedge clk);
      check("startgo_rdy", tsr_rdy, 1'b1);
      check("startgo_req", dram_req, 1'b0);
      start = 1'b0; tsr_go = 1'b0;
      @(negedge clk);

      // Abort mid-DRAW of an xs=7 task, then accept a new task at once.
      tsr_page = 8'h40; tsr_line = 9'h001; tsr_addr = 6'd2; tsr_xs = 3'd7;
      tsr_xf = 1'b0; tsr_x = 9'd10; tsr_pal = 4'd1; tsr_go = 1'b1;
      @(negedge clk);
      tsr_go = 1'b0;
      check("abort_req", dram_req, 1'b1);
      dram_next = 1'b1; dram_rdata = 16'h1111;
      @(negedge clk);
      dram_next = 1'b0;
      start = 1'b1;
      @(negedge clk);
      check("abort_req_off", dram_req, 1'b0);
      check("abort_we_off", lb_we, 1'b0);
      check("abort_rdy", tsr_rdy, 1'b1);
      start = 1'b0;
      tsr_page = 8'h20; tsr_line = 9'h003; tsr_addr = 6'd1; tsr_xs = 3'd0;
      tsr_go = 1'b1;
      @(negedge clk);
      tsr_go = 1'b0;
      check("reaccept_rdy", tsr_rdy, 1'b0);
      check("reaccept_req", dram_req, 1'b1);
      check("reaccept_addr", dram_addr, model_addr(8'h20, 9'h003, 2));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("final_rdy", tsr_rdy, 1'b1);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
